// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 access types, memory size codes,
// FSM state encoding and small decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_1 = 2'b00;
  localparam logic [1:0] SZ_2 = 2'b01;
  localparam logic [1:0] SZ_4 = 2'b11;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  function automatic logic [1:0] size_code(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_code = SZ_1;
      F3_H, F3_HU: size_code = SZ_2;
      default:     size_code = SZ_4;
    endcase
  endfunction

  // Unsigned variants only make sense for loads.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: funct3_legal = 1'b1;
      F3_BU, F3_HU:     funct3_legal = !we;
      default:          funct3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational sign/zero extension of a raw memory word according to the load funct3.
module load_extender
  import lsu_pkg::*;
#(
  parameter int BYTE_SIZE = 4
) (
  input  logic [2:0]             funct3,
  input  logic [BYTE_SIZE*8-1:0] raw,
  output logic [BYTE_SIZE*8-1:0] ext
);

  localparam int DW = BYTE_SIZE * 8;

  always_comb begin
    ext = raw;
    case (funct3)
      F3_B:    ext = {{(DW-8){raw[7]}}, raw[7:0]};
      F3_BU:   ext = {{(DW-8){1'b0}}, raw[7:0]};
      F3_H:    ext = {{(DW-16){raw[15]}}, raw[15:0]};
      F3_HU:   ext = {{(DW-16){1'b0}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit driving a combinational-read data memory port.
// Define LSU_MISALIGN_TRAP_EN to report misaligned H/HU/W accesses as errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BYTE_SIZE  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BYTE_SIZE*8-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [BYTE_SIZE*8-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]            mem_size,
  output logic [BYTE_SIZE*8-1:0] mem_wd,
  input  logic [BYTE_SIZE*8-1:0] mem_rd
);

  localparam int DW = BYTE_SIZE * 8;

  logic [1:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [DW-1:0]         ext_data;
  logic                  misaligned;
  logic                  access_err;

  load_extender #(.BYTE_SIZE(BYTE_SIZE)) u_ext (
    .funct3 (funct3_q),
    .raw    (mem_rd),
    .ext    (ext_data)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (funct3_q)
      F3_H, F3_HU: misaligned = addr_q[0];
      F3_W:        misaligned = |addr_q[1:0];
      default:     misaligned = 1'b0;
    endcase
  end
`else
  always_comb begin
    misaligned = 1'b0;
  end
`endif

  assign access_err = !funct3_legal(we_q, funct3_q) || misaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid && req_ready) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured on accept; the response is captured at the end of ACCESS.
  always_comb begin
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (state_q == IDLE && req_valid && req_ready) begin
      we_d     = req_we;
      funct3_d = req_funct3;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
    end
    if (state_q == ACCESS) begin
      err_d   = access_err;
      rdata_d = (we_q || access_err) ? '0 : ext_data;
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_size   = SZ_1;
    mem_wd     = '0;
    case (state_q)
      IDLE: req_ready = !reset;
      ACCESS: begin
        mem_addr = addr_q;
        mem_size = size_code(funct3_q);
        mem_wd   = wdata_q;
        mem_we   = we_q && !access_err;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a per-cycle expectation table.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_load_store_unit;

  localparam int MAXC = 4096;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  load_store_unit #(.ADDR_WIDTH(32), .BYTE_SIZE(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_size   (mem_size),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  // Expected behaviour indexed by the cycle in which it must be visible.
  bit          busy   [MAXC];
  bit          acc    [MAXC];
  bit          resp   [MAXC];
  bit          e_mwe  [MAXC];
  logic [31:0] e_addr [MAXC];
  logic [31:0] e_wd   [MAXC];
  bit          e_szchk[MAXC];
  logic [1:0]  e_size [MAXC];
  bit          e_err  [MAXC];
  logic [31:0] e_rdata[MAXC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit legal(input bit we, input logic [2:0] f3);
    return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit misal(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    return (addr % nbytes(f3)) != 0;
`else
    return (f3 == 3'd7) && (addr == 32'h1) && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] rd);
    logic [31:0] v;
    case (f3)
      3'd0: begin v = rd & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'd1: begin v = rd & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'd4: v = rd & 32'hFF;
      3'd5: v = rd & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  // Compare process: every cycle, all outputs against the table.
  always @(negedge clk) begin
    if (!done && cyc < MAXC) begin
      chk("req_ready", 32'(req_ready), 32'(!reset && !busy[cyc]));
      chk("resp_valid", 32'(resp_valid), 32'(resp[cyc]));
      if (acc[cyc]) begin
        chk("mem_we", 32'(mem_we), 32'(e_mwe[cyc]));
        chk("mem_addr", mem_addr, e_addr[cyc]);
        chk("mem_wd", mem_wd, e_wd[cyc]);
        if (e_szchk[cyc]) chk("mem_size", 32'(mem_size), 32'(e_size[cyc]));
      end else begin
        chk("mem_we_idle", 32'(mem_we), 32'd0);
        chk("mem_addr_idle", mem_addr, 32'd0);
        chk("mem_wd_idle", mem_wd, 32'd0);
        chk("mem_size_idle", 32'(mem_size), 32'd0);
      end
      if (resp[cyc]) begin
        chk("resp_rdata", resp_rdata, e_rdata[cyc]);
        chk("resp_err", 32'(resp_err), 32'(e_err[cyc]));
      end
    end
  end

  // Called at a negedge where the LSU is idle; returns at the negedge after the response.
  task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdv, input bit garbage);
    int a;
    bit e;
    a = cyc + 1;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    mem_rd     = $urandom;
    e = !legal(we, f3) || misal(f3, addr);
    busy[a]    = 1'b1;
    busy[a+1]  = 1'b1;
    acc[a]     = 1'b1;
    e_mwe[a]   = we && !e;
    e_addr[a]  = addr;
    e_wd[a]    = wdata;
    e_szchk[a] = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    e_size[a]  = 2'(nbytes(f3) - 1);
    resp[a+1]    = 1'b1;
    e_err[a+1]   = e;
    e_rdata[a+1] = (we || e) ? 32'd0 : ext(f3, rdv);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_rd    = (i == 0) ? rdv : $urandom;
      req_valid = garbage;
      if (garbage) begin
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Store accepted, then reset asserted during its ACCESS cycle.
  task automatic checkOutput_resetMidStore();
    int a;
    a = cyc + 1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h20;
    req_wdata  = 32'hCAFEF00D;
    busy[a]    = 1'b1;
    acc[a]     = 1'b1;
    e_mwe[a]   = 1'b1;
    e_addr[a]  = 32'h20;
    e_wd[a]    = 32'hCAFEF00D;
    e_szchk[a] = 1'b1;
    e_size[a]  = 2'b11;
    @(negedge clk);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mem_we_async_reset", 32'(mem_we), 32'd0);
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_rd     = 32'd0;

    chk("model_lb", ext(3'd0, 32'h000000EF), 32'hFFFFFFEF);
    chk("model_lbu", ext(3'd4, 32'h000000EF), 32'h000000EF);
    chk("model_lh", ext(3'd1, 32'h00008001), 32'hFFFF8001);
    chk("model_lhu", ext(3'd5, 32'h00008001), 32'h00008001);
    chk("model_store_bu_illegal", 32'(legal(1'b1, 3'd4)), 32'd0);

    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    applyStimulus(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    applyStimulus(1'b0, 3'd0, 32'h10, 32'h0, 32'h000000EF, 1'b0);
    applyStimulus(1'b0, 3'd4, 32'h10, 32'h0, 32'h000000EF, 1'b0);
    applyStimulus(1'b0, 3'd1, 32'h10, 32'h0, 32'h00008001, 1'b0);
    applyStimulus(1'b0, 3'd5, 32'h10, 32'h0, 32'h00008001, 1'b0);
    applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 32'h12345678, 1'b1);
    applyStimulus(1'b1, 3'd4, 32'h10, 32'h55AA55AA, 32'hFFFFFFFF, 1'b0);
    applyStimulus(1'b0, 3'd3, 32'h14, 32'h0, 32'h87654321, 1'b1);
    checkOutput_resetMidStore();
    applyStimulus(1'b1, 3'd2, 32'h11, 32'h01020304, 32'h0, 1'b0);
    applyStimulus(1'b0, 3'd1, 32'h13, 32'h0, 32'h0000FFFF, 1'b0);
    applyStimulus(1'b0, 3'd2, 32'hFFFFFFFC, 32'h0, 32'hA5A5A5A5, 1'b0);

    for (int n = 0; n < 300; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        @(negedge clk);
      end
      applyStimulus(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the core's data-memory port.
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Drives the byte-addressed data-memory port (write enable, address, size code, write data) and samples its combinational read data.
- Returns a sign- or zero-extended load result, or a store acknowledge, over a one-cycle response pulse.

Parameters:
- ADDR_WIDTH, 32, width of request and memory address.
- BYTE_SIZE, 4, bytes per data word; data width is BYTE_SIZE*8.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  LSU can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  BYTE_SIZE*8  store data, low-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  BYTE_SIZE*8  extended load data; 0 for stores and errors.
- resp_err  output  1  qualified by resp_valid; illegal funct3 (or misaligned, see the optional feature).
- mem_we  output  1  data-memory write enable.
- mem_addr  output  ADDR_WIDTH  data-memory byte address.
- mem_size  output  2  bytes-minus-one code: 00 = 1, 01 = 2, 11 = 4.
- mem_wd  output  BYTE_SIZE*8  data-memory write data.
- mem_rd  input  BYTE_SIZE*8  data-memory read data, combinational from mem_addr.

Behaviour:
- Reset values: state IDLE; latched request registers 0; req_ready, resp_valid, resp_err, mem_we = 0; resp_rdata, mem_addr, mem_wd, mem_size = 0.
- req_ready is forced to 0 while reset is high.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch we, funct3, addr, wdata; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (exactly one cycle):
  - mem_addr = latched addr.
  - mem_size: 00 for B/BU, 01 for H/HU, 11 for W.
  - mem_wd = latched wdata, unshifted; the memory writes bytes starting at mem_addr.
  - mem_we = 1 only if this is a store with legal funct3.
  - Load: register mem_rd, then extend. B sign-extends bit 7; BU zero-extends [7:0]; H sign-extends bit 15; HU zero-extends [15:0]; W passes through.
  - Go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle; resp_rdata and resp_err are held for that cycle.
  - req_ready = 0.
  - Return to IDLE.
- Outside ACCESS: mem_we = 0 and mem_addr/mem_wd/mem_size = 0.
- Timing: request accepted at edge N; memory access during cycle N+1; resp_valid during cycle N+2. Throughput is 1 request per 3 cycles. Back-to-back requests are accepted in the IDLE cycle after RESP.
- Illegal funct3 (011, 110, 111, and 100/101 with a store):
  - No mem_we.
  - resp_err = 1, resp_rdata = 0.
  - Normal 3-cycle timing.
- Address wrap: the full ADDR_WIDTH address is passed unchanged; wrap within memory depth is the memory's responsibility.
- req_valid in ACCESS/RESP is ignored; the request must be held until req_ready.
- Reset mid-operation: immediate return to IDLE; mem_we drops asynchronously; any pending response is discarded with no resp_valid.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- When defined:
  - H/HU with addr[0] = 1 is misaligned.
  - W with addr[1:0] != 00 is misaligned.
  - A misaligned access gets resp_err = 1, mem_we is never asserted, and resp_rdata = 0, with the same timing.
- When undefined: misaligned accesses proceed unchanged; the memory handles them byte-wise.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - mem_size codes: SZ_1, SZ_2, SZ_4.
  - FSM state encoding: IDLE, ACCESS, RESP, as a 2-bit localparam set.
- One natural sub-module, load_extender: combinational funct3-plus-raw-word to extended-word, instantiated by load_store_unit.

Test Plan:
- Reset, then SW addr=0x10 wdata=0xDEADBEEF:
  - mem_we=1 for exactly one cycle with mem_addr=0x10, mem_size=11.
  - resp_valid two cycles after accept, resp_err=0.
- LB addr=0x10 with mem_rd=0x000000EF -> resp_rdata=0xFFFFFFEF. LBU, same stimulus -> 0x000000EF.
- LH with mem_rd=0x00008001 -> resp_rdata=0xFFFF8001. LHU, same stimulus -> 0x00008001. LW -> mem_rd unchanged.
- Store with funct3=100 -> no mem_we, resp_valid with resp_err=1, resp_rdata=0.
- Assert reset during ACCESS of a store -> mem_we falls immediately; no resp_valid; req_ready=1 the cycle after reset deasserts.
- With LSU_MISALIGN_TRAP_EN: SW addr=0x11 -> resp_err=1, mem_we never 1. Without the macro -> write occurs at 0x11, resp_err=0.
